dp_ram_arb: RTL and testbench
=============================

DP_RAM_ARB -- requirements
Module: dp_ram_arb

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 12, meaning RAM word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning bits per RAM word.
REQ-003 The block SHALL have a single clock, clk (input, 1), sampled on its rising edge.
REQ-004 The block SHALL have rst (input, 1), with synchronous, active-high reset.
REQ-005 Per requester x in {a,b}, the block SHALL have req_valid_x (input, 1), meaning a request is present.
REQ-006 Per requester x, the block SHALL have req_write_x (input, 1), meaning 1=write and 0=read.
REQ-007 Per requester x, the block SHALL have req_addr_x (input, ADDRESS_WIDTH), meaning the word address.
REQ-008 Per requester x, the block SHALL have req_wdata_x (input, DATA_WIDTH), meaning the write data.
REQ-009 Per requester x, the block SHALL have req_ready_x (output, 1), meaning the request is accepted this cycle.
REQ-010 Per requester x, the block SHALL have rsp_valid_x (output, 1) and rsp_rdata_x (output, DATA_WIDTH), meaning read data is returned.
REQ-011 The RAM side SHALL provide ram_write_en (output, 1), ram_write_address and ram_read_address (outputs, ADDRESS_WIDTH), ram_write_data_in (output, DATA_WIDTH), and ram_read_data_out (input, DATA_WIDTH).

Function
REQ-012 A request SHALL be accepted in any cycle where req_valid_x && req_ready_x; requesters SHALL hold all req_* stable while valid && !ready.
REQ-013 Read and write channels SHALL be arbitrated independently, so one read and one write are granted per cycle at most.
REQ-014 An uncontested request SHALL be granted in the same cycle, with req_ready_x asserted combinationally.
REQ-015 When both requesters contend for one channel, the requester holding that channel's priority pointer SHALL win; after every granted contention, the pointer SHALL move to the loser.
REQ-016 A granted write SHALL drive ram_write_en=1, ram_write_address and ram_write_data_in from the winner in the same cycle; with no write grant, ram_write_en=0.
REQ-017 A granted read SHALL drive ram_read_address from the winner in the same cycle; with no read grant, ram_read_address SHALL hold its last value.
REQ-018 A read granted in cycle N SHALL assert rsp_valid_x for exactly cycle N+1, with rsp_rdata_x = ram_read_data_out (1-cycle latency, no backpressure).
REQ-019 The rsp_valid_* outputs SHALL be registered, and rsp_rdata_x SHALL be zero whenever rsp_valid_x=0.
REQ-020 A read and a write to the same address in one cycle SHALL return the newly written data (write-first).
REQ-021 Back-to-back reads SHALL sustain one response per cycle with no bubbles.

Reset
REQ-022 While rst=1, req_ready_a/b, ram_write_en and rsp_valid_a/b SHALL be 0, and no grant SHALL occur.
REQ-023 Reset SHALL set both priority pointers to requester a and ram_read_address to 0.
REQ-024 Reset asserted in the cycle after a read grant SHALL suppress that response.

Configuration
REQ-025 With macro DP_RAM_ARB_STATS_EN defined, the block SHALL add output conflict_count (16 bits), a saturating count of cycles with contention on either channel, cleared by rst.
REQ-026 Without DP_RAM_ARB_STATS_EN, the port and counter SHALL be absent and behaviour otherwise identical.

Structure
REQ-027 Package dp_ram_arb_pkg SHALL hold the requester-ID enum (REQ_A=0, REQ_B=1) and the STATS_WIDTH=16 constant.
REQ-028 Sub-module rr_arb2 (two-input round-robin arbiter with pointer register) SHALL be instantiated once per channel.

Verification
REQ-029 After reset, a write of 0x5A to addr 0x010 by a, then a read of 0x010 by b, SHALL give rsp_valid_b=1 and rsp_rdata_b=0x5A one cycle after b's grant.
REQ-030 With a and b both issuing writes every cycle for 4 cycles, grants SHALL alternate a,b,a,b.
REQ-031 A read by a and a write by b in the same cycle SHALL both be granted with ready_a=ready_b=1.
REQ-032 A same-cycle write 0x33 to addr 0x7 (a) and read of 0x7 (b) SHALL give rsp_rdata_b=0x33.
REQ-033 Asserting rst the cycle after a read grant SHALL keep rsp_valid=0, and the next contention SHALL be won by a.
REQ-034 With DP_RAM_ARB_STATS_EN defined, 70000 contended cycles SHALL give conflict_count=0xFFFF.

Source files
------------

// File: rtl/dp_ram_arb_pkg.sv
// Shared types and constants for the dual-requester RAM arbiter.
package dp_ram_arb_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  localparam int unsigned STATS_WIDTH = 16;

endpackage

// File: rtl/dp_ram_arb_rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves to the loser after each contended grant.
module rr_arb2
  import dp_ram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o,
  output logic contend_o
);

  req_id_e ptr_q, ptr_d;
  logic    both;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= REQ_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    both      = req_a_i & req_b_i;
    gnt_a_o   = 1'b0;
    gnt_b_o   = 1'b0;
    contend_o = 1'b0;
    ptr_d     = ptr_q;
    if (!rst) begin
      contend_o = both;
      if (both) begin
        if (ptr_q == REQ_A) begin
          gnt_a_o = 1'b1;
          ptr_d   = REQ_B;
        end else begin
          gnt_b_o = 1'b1;
          ptr_d   = REQ_A;
        end
      end else begin
        gnt_a_o = req_a_i;
        gnt_b_o = req_b_i;
      end
    end
  end

endmodule

// File: rtl/dp_ram_arb.sv
// Two-requester front end for a synchronous dual-port RAM with independent read/write arbitration.
// Optional conflict statistics are enabled with macro DP_RAM_ARB_STATS_EN.
module dp_ram_arb
  import dp_ram_arb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid_a,
  input  logic                     req_write_a,
  input  logic [ADDRESS_WIDTH-1:0] req_addr_a,
  input  logic [DATA_WIDTH-1:0]    req_wdata_a,
  output logic                     req_ready_a,
  output logic                     rsp_valid_a,
  output logic [DATA_WIDTH-1:0]    rsp_rdata_a,
  input  logic                     req_valid_b,
  input  logic                     req_write_b,
  input  logic [ADDRESS_WIDTH-1:0] req_addr_b,
  input  logic [DATA_WIDTH-1:0]    req_wdata_b,
  output logic                     req_ready_b,
  output logic                     rsp_valid_b,
  output logic [DATA_WIDTH-1:0]    rsp_rdata_b,
  output logic                     ram_write_en,
  output logic [ADDRESS_WIDTH-1:0] ram_write_address,
  output logic [ADDRESS_WIDTH-1:0] ram_read_address,
  output logic [DATA_WIDTH-1:0]    ram_write_data_in,
  input  logic [DATA_WIDTH-1:0]    ram_read_data_out
`ifdef DP_RAM_ARB_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0]   conflict_count
`endif
);

  logic rd_req_a, rd_req_b, wr_req_a, wr_req_b;
  logic rd_gnt_a, rd_gnt_b, wr_gnt_a, wr_gnt_b;
  logic rd_contend, wr_contend;

  logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                     rsp_valid_a_q, rsp_valid_a_d;
  logic                     rsp_valid_b_q, rsp_valid_b_d;
  logic                     byp_q, byp_d;
  logic [DATA_WIDTH-1:0]    byp_data_q, byp_data_d;
  logic [DATA_WIDTH-1:0]    rsp_data;

  assign rd_req_a = req_valid_a & ~req_write_a;
  assign rd_req_b = req_valid_b & ~req_write_b;
  assign wr_req_a = req_valid_a & req_write_a;
  assign wr_req_b = req_valid_b & req_write_b;

  rr_arb2 u_rd_arb (
    .clk       (clk),
    .rst       (rst),
    .req_a_i   (rd_req_a),
    .req_b_i   (rd_req_b),
    .gnt_a_o   (rd_gnt_a),
    .gnt_b_o   (rd_gnt_b),
    .contend_o (rd_contend)
  );

  rr_arb2 u_wr_arb (
    .clk       (clk),
    .rst       (rst),
    .req_a_i   (wr_req_a),
    .req_b_i   (wr_req_b),
    .gnt_a_o   (wr_gnt_a),
    .gnt_b_o   (wr_gnt_b),
    .contend_o (wr_contend)
  );

  assign req_ready_a = rd_gnt_a | wr_gnt_a;
  assign req_ready_b = rd_gnt_b | wr_gnt_b;

  always_comb begin
    ram_write_en      = wr_gnt_a | wr_gnt_b;
    ram_write_address = wr_gnt_b ? req_addr_b : req_addr_a;
    ram_write_data_in = wr_gnt_b ? req_wdata_b : req_wdata_a;

    if (rst) begin
      rd_addr_d = '0;
    end else if (rd_gnt_a) begin
      rd_addr_d = req_addr_a;
    end else if (rd_gnt_b) begin
      rd_addr_d = req_addr_b;
    end else begin
      rd_addr_d = rd_addr_q;
    end

    rsp_valid_a_d = rd_gnt_a;
    rsp_valid_b_d = rd_gnt_b;

    // The RAM itself may return old data on a same-address collision; forward the write instead.
    byp_d      = ram_write_en & (rd_gnt_a | rd_gnt_b) & (ram_write_address == rd_addr_d);
    byp_data_d = ram_write_data_in;
  end

  assign ram_read_address = rd_addr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q     <= '0;
      rsp_valid_a_q <= 1'b0;
      rsp_valid_b_q <= 1'b0;
      byp_q         <= 1'b0;
      byp_data_q    <= '0;
    end else begin
      rd_addr_q     <= rd_addr_d;
      rsp_valid_a_q <= rsp_valid_a_d;
      rsp_valid_b_q <= rsp_valid_b_d;
      byp_q         <= byp_d;
      byp_data_q    <= byp_data_d;
    end
  end

  assign rsp_data = byp_q ? byp_data_q : ram_read_data_out;

  // Gating with rst drops a response whose grant was followed by reset.
  assign rsp_valid_a = rsp_valid_a_q & ~rst;
  assign rsp_valid_b = rsp_valid_b_q & ~rst;
  assign rsp_rdata_a = rsp_valid_a ? rsp_data : '0;
  assign rsp_rdata_b = rsp_valid_b ? rsp_data : '0;

`ifdef DP_RAM_ARB_STATS_EN
  logic [STATS_WIDTH-1:0] conflict_q, conflict_d;

  always_comb begin
    conflict_d = conflict_q;
    if ((rd_contend | wr_contend) && (conflict_q != '1)) begin
      conflict_d = conflict_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_count = conflict_q;
`else
  logic unused_contend;
  assign unused_contend = rd_contend ^ wr_contend;
`endif

endmodule

// File: tb/tb_dp_ram_arb.sv
// Scoreboard bench for dp_ram_arb with a behavioural read-first synchronous RAM.
module tb_dp_ram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_a, req_write_a, req_ready_a, rsp_valid_a;
  logic [11:0] req_addr_a;
  logic [7:0]  req_wdata_a, rsp_rdata_a;
  logic        req_valid_b, req_write_b, req_ready_b, rsp_valid_b;
  logic [11:0] req_addr_b;
  logic [7:0]  req_wdata_b, rsp_rdata_b;
  logic        ram_write_en;
  logic [11:0] ram_write_address, ram_read_address;
  logic [7:0]  ram_write_data_in, ram_read_data_out;
`ifdef DP_RAM_ARB_STATS_EN
  logic [15:0] conflict_count;
`endif

  dp_ram_arb dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_a       (req_valid_a),
    .req_write_a       (req_write_a),
    .req_addr_a        (req_addr_a),
    .req_wdata_a       (req_wdata_a),
    .req_ready_a       (req_ready_a),
    .rsp_valid_a       (rsp_valid_a),
    .rsp_rdata_a       (rsp_rdata_a),
    .req_valid_b       (req_valid_b),
    .req_write_b       (req_write_b),
    .req_addr_b        (req_addr_b),
    .req_wdata_b       (req_wdata_b),
    .req_ready_b       (req_ready_b),
    .rsp_valid_b       (rsp_valid_b),
    .rsp_rdata_b       (rsp_rdata_b),
    .ram_write_en      (ram_write_en),
    .ram_write_address (ram_write_address),
    .ram_read_address  (ram_read_address),
    .ram_write_data_in (ram_write_data_in),
    .ram_read_data_out (ram_read_data_out)
`ifdef DP_RAM_ARB_STATS_EN
    ,
    .conflict_count    (conflict_count)
`endif
  );

  always #5 clk = ~clk;

  // Read-first RAM: a same-address collision returns the old word.
  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_write_address] <= ram_write_data_in;
    ram_read_data_out <= mem[ram_read_address];
  end

  typedef struct {
    logic       id;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t        sb[$];
  int          nchecks = 0;
  int          nerrors = 0;
  int          cyc_cnt = 0;
  logic [11:0] last_raddr = '0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic mon_port(input logic id, input logic v, input logic [7:0] d);
    exp_t e;
    if (v) begin
      if (sb.size() == 0) begin
        check(id ? "stray_rsp_b" : "stray_rsp_a", 32'(v), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_id", 32'(id), 32'(e.id));
        check("rsp_data", 32'(d), 32'(e.data));
        check("rsp_cycle", 32'(cyc_cnt), 32'(e.due));
      end
    end else begin
      check(id ? "idle_rdata_b" : "idle_rdata_a", 32'(d), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon_port(1'b0, rsp_valid_a, rsp_rdata_a);
    mon_port(1'b1, rsp_valid_b, rsp_rdata_b);
  end

  task automatic drive(input logic va, wa, input logic [11:0] aa, input logic [7:0] da,
                       input logic vb, wb, input logic [11:0] ab, input logic [7:0] db);
    req_valid_a = va; req_write_a = wa; req_addr_a = aa; req_wdata_a = da;
    req_valid_b = vb; req_write_b = wb; req_addr_b = ab; req_wdata_b = db;
  endtask

  // One cycle: drive, check grants/RAM side mid-cycle, queue any expected read response.
  task automatic cyc(input logic va, wa, input logic [11:0] aa, input logic [7:0] da,
                     input logic vb, wb, input logic [11:0] ab, input logic [7:0] db,
                     input logic era, erb, input logic [7:0] rexp, input logic push);
    logic ewa, ewb;
    drive(va, wa, aa, da, vb, wb, ab, db);
    @(negedge clk);
    ewa = era & va & wa;
    ewb = erb & vb & wb;
    check("ready_a", 32'(req_ready_a), 32'(era));
    check("ready_b", 32'(req_ready_b), 32'(erb));
    check("write_en", 32'(ram_write_en), 32'(ewa | ewb));
    if (ewa | ewb) begin
      check("write_addr", 32'(ram_write_address), 32'(ewa ? aa : ab));
      check("write_data", 32'(ram_write_data_in), 32'(ewa ? da : db));
    end
    if (era & va & ~wa) begin
      if (push) sb.push_back('{id: 1'b0, data: rexp, due: cyc_cnt + 1});
      last_raddr = aa;
    end
    if (erb & vb & ~wb) begin
      if (push) sb.push_back('{id: 1'b1, data: rexp, due: cyc_cnt + 1});
      last_raddr = ab;
    end
    check("read_addr", 32'(ram_read_address), 32'(last_raddr));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 12'h055, 8'h00, 1'b1, 1'b0, 12'h066, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_ready_a", 32'(req_ready_a), 32'd0);
      check("rst_ready_b", 32'(req_ready_b), 32'd0);
      check("rst_write_en", 32'(ram_write_en), 32'd0);
      check("rst_rsp_valid", 32'({rsp_valid_a, rsp_valid_b}), 32'd0);
      @(posedge clk);
      #1;
    end
    check("rst_read_addr", 32'(ram_read_address), 32'd0);
    last_raddr = '0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 12'h0, 8'h0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    rst = 1'b1;
    drive(1'b0, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 12'h0, 8'h0);
    @(posedge clk);
    #1;
    do_reset();

    // Write then read back through the other requester
    cyc(1, 1, 12'h010, 8'h5A, 0, 0, 12'h000, 8'h00, 1, 0, 8'h00, 1);
    cyc(0, 0, 12'h000, 8'h00, 1, 0, 12'h010, 8'h00, 0, 1, 8'h5A, 1);

    // Contended writes alternate; losers hold their request
    cyc(1, 1, 12'h020, 8'h11, 1, 1, 12'h021, 8'h22, 1, 0, 8'h00, 1);
    cyc(1, 1, 12'h020, 8'h12, 1, 1, 12'h021, 8'h22, 0, 1, 8'h00, 1);
    cyc(1, 1, 12'h020, 8'h12, 1, 1, 12'h022, 8'h44, 1, 0, 8'h00, 1);
    cyc(1, 1, 12'h023, 8'h55, 1, 1, 12'h022, 8'h44, 0, 1, 8'h00, 1);
    // Write by a and read by b on separate channels, then back-to-back reads
    cyc(1, 1, 12'h023, 8'h55, 1, 0, 12'h021, 8'h00, 1, 1, 8'h22, 1);
    cyc(1, 0, 12'h023, 8'h00, 1, 0, 12'h022, 8'h00, 1, 0, 8'h55, 1);
    cyc(0, 0, 12'h000, 8'h00, 1, 0, 12'h022, 8'h00, 0, 1, 8'h44, 1);
    cyc(1, 0, 12'h020, 8'h00, 0, 0, 12'h000, 8'h00, 1, 0, 8'h12, 1);
    cyc(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 0, 8'h00, 1);

    // Read by a alongside write by b
    cyc(1, 0, 12'h010, 8'h00, 1, 1, 12'h030, 8'h77, 1, 1, 8'h5A, 1);
    // Same-address write and read: write-first
    cyc(1, 1, 12'h007, 8'h33, 1, 0, 12'h007, 8'h00, 1, 1, 8'h33, 1);

    // Read pointer sits at b here; b wins, then a wins, then reset drops a's response
    cyc(1, 0, 12'h030, 8'h00, 1, 0, 12'h010, 8'h00, 0, 1, 8'h5A, 1);
    cyc(1, 0, 12'h030, 8'h00, 1, 0, 12'h010, 8'h00, 1, 0, 8'h00, 0);
    do_reset();
    cyc(1, 0, 12'h030, 8'h00, 1, 0, 12'h010, 8'h00, 1, 0, 8'h77, 1);
    cyc(0, 0, 12'h000, 8'h00, 1, 0, 12'h010, 8'h00, 0, 1, 8'h5A, 1);
    cyc(1, 1, 12'h040, 8'h01, 1, 1, 12'h041, 8'h02, 1, 0, 8'h00, 1);
    cyc(0, 0, 12'h000, 8'h00, 1, 1, 12'h041, 8'h02, 0, 1, 8'h00, 1);
    cyc(1, 0, 12'h041, 8'h00, 0, 0, 12'h000, 8'h00, 1, 0, 8'h02, 1);
    cyc(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 0, 8'h00, 1);
    cyc(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 0, 8'h00, 1);
    check("pending_rsp", 32'(sb.size()), 32'd0);

`ifdef DP_RAM_ARB_STATS_EN
    do_reset();
    @(negedge clk);
    check("conflict_after_rst", 32'(conflict_count), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 12'h000, 8'h00, 1'b1, 1'b1, 12'h000, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("conflict_3", 32'(conflict_count), 32'd3);
    repeat (70000 - 3) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 12'h0, 8'h0);
    @(negedge clk);
    check("conflict_sat", 32'(conflict_count), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
